// File: rtl/mem_arbiter.sv
// Arbiter sharing one memory port between instruction fetch (read-only) and data (r/w).
// The grant is registered; memory drive and response forwarding are combinational from it.
module mem_arbiter #(
  parameter int PRIORITY = 0,
  parameter int TIMEOUT  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_read,
  input  logic [7:0] i_addr,
  output logic       i_resp,
  output logic [7:0] i_rdata,
  input  logic       d_read,
  input  logic       d_write,
  input  logic [7:0] d_addr,
  input  logic [7:0] d_wdata,
  output logic       d_resp,
  output logic [7:0] d_rdata,
  output logic       mem_read,
  output logic       mem_write,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic       mem_resp,
  input  logic [7:0] mem_rdata,
  output logic [1:0] grant,
  output logic       timeout_err
);

  // Encoding doubles as the grant status value.
  typedef enum logic [1:0] {IDLE = 2'b00, SERVE_I = 2'b01, SERVE_D = 2'b10} state_e;

  localparam logic       LAST_I = 1'b0;
  localparam logic       LAST_D = 1'b1;
  localparam logic [7:0] TO_M1  = 8'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e     state_q, state_d;
  logic       last_q, last_d;
  logic [7:0] cnt_q, cnt_d;
  logic       terr_q, terr_d;

  logic i_req, d_req, gnt_i, gnt_d, req_g, wd_fire;

  always_comb begin
    i_req   = i_read;
    d_req   = d_read | d_write;
    gnt_i   = (state_q == SERVE_I);
    gnt_d   = (state_q == SERVE_D);
    req_g   = gnt_i ? i_req : (gnt_d ? d_req : 1'b0);
    // An aborted request (dropped before resp) never trips the watchdog.
    wd_fire = (TIMEOUT > 0) && (gnt_i || gnt_d) && req_g && !mem_resp && (cnt_q == TO_M1);
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    terr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (i_req && d_req)
          state_d = ((PRIORITY != 0) || (last_q == LAST_I)) ? SERVE_D : SERVE_I;
        else if (i_req)
          state_d = SERVE_I;
        else if (d_req)
          state_d = SERVE_D;
      end
      SERVE_I, SERVE_D: begin
        if (mem_resp) begin
          state_d = IDLE;
          last_d  = gnt_d ? LAST_D : LAST_I;
          cnt_d   = 8'd0;
        end else if (!req_g) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else if (wd_fire) begin
          state_d = IDLE;
          last_d  = gnt_d ? LAST_D : LAST_I;
          cnt_d   = 8'd0;
          terr_d  = 1'b1;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= LAST_D;
      cnt_q   <= 8'd0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
    end
  end

  always_comb begin
    mem_read  = gnt_i ? i_read : (gnt_d ? (d_read & ~d_write) : 1'b0);
    mem_write = gnt_d & d_write;
    mem_addr  = gnt_i ? i_addr : (gnt_d ? d_addr : 8'd0);
    mem_wdata = gnt_d ? d_wdata : 8'd0;
    i_resp    = gnt_i & (mem_resp | wd_fire);
    d_resp    = gnt_d & (mem_resp | wd_fire);
    i_rdata   = (gnt_i && !wd_fire) ? mem_rdata : 8'd0;
    d_rdata   = (gnt_d && !wd_fire) ? mem_rdata : 8'd0;
  end

  assign grant       = state_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: instance 0 is round-robin with TIMEOUT=4, instance 1 is fixed D priority
// with no watchdog. Each has a zero-latency memory stub whose response can be stalled.
module tb_mem_arbiter;
  logic clk, rst;
  logic [1:0] ir, dr, dw, stall;
  logic [1:0][7:0] ia, da, dwd;
  logic       iresp [2];
  logic       dresp [2];
  logic       mrd   [2];
  logic       mwr   [2];
  logic       mresp [2];
  logic       terr  [2];
  logic [7:0] irdata[2];
  logic [7:0] drdata[2];
  logic [7:0] maddr [2];
  logic [7:0] mwd   [2];
  logic [7:0] mrdata[2];
  logic [1:0] gnt   [2];

  int pass = 0;
  int total = 0;
  int fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [7:0] mem [256];

    mem_arbiter #(.PRIORITY(g), .TIMEOUT(g == 0 ? 4 : 0)) u_dut (
      .clk(clk), .rst(rst),
      .i_read(ir[g]), .i_addr(ia[g]), .i_resp(iresp[g]), .i_rdata(irdata[g]),
      .d_read(dr[g]), .d_write(dw[g]), .d_addr(da[g]), .d_wdata(dwd[g]),
      .d_resp(dresp[g]), .d_rdata(drdata[g]),
      .mem_read(mrd[g]), .mem_write(mwr[g]), .mem_addr(maddr[g]), .mem_wdata(mwd[g]),
      .mem_resp(mresp[g]), .mem_rdata(mrdata[g]),
      .grant(gnt[g]), .timeout_err(terr[g])
    );

    // Memory contents after reset: mem[a] = a + 0xA2, so mem[3] = 0xA5.
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int a = 0; a < 256; a++) mem[a] <= 8'(a) + 8'hA2;
      end else if (mwr[g] && mresp[g]) begin
        mem[maddr[g]] <= mwd[g];
      end
    end
    assign mresp[g]  = (mrd[g] | mwr[g]) & ~stall[g];
    assign mrdata[g] = mem[maddr[g]];
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) pass++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic rst_pulse();
    #1 rst = 1'b1;
    #1 rst = 1'b0;
  endtask

  logic [1:0] exp3 [7];
  logic pi, pd;

  initial begin
    exp3 = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    rst = 1'b1;
    ir = '0; dr = '0; dw = '0; stall = '0;
    ia = '0; da = '0; dwd = '0;
    #3;
    chk("rst_grant", gnt[0], 2'b00);
    chk("rst_mrd", mrd[0], 1'b0);
    chk("rst_mwr", mwr[1], 1'b0);
    chk("rst_terr", terr[0], 1'b0);
    rst = 1'b0;

    // single I read of mem[3]
    ir[0] = 1'b1; ia[0] = 8'd3;
    tick(); #1;
    chk("t1_grant", gnt[0], 2'b01);
    chk("t1_mrd", mrd[0], 1'b1);
    chk("t1_maddr", maddr[0], 8'd3);
    chk("t1_iresp", iresp[0], 1'b1);
    chk("t1_irdata", irdata[0], 8'hA5);
    chk("t1_dresp", dresp[0], 1'b0);
    tick(); ir[0] = 1'b0; #1;
    chk("t1_idle", gnt[0], 2'b00);

    // I read and D write to the same address tie right after reset
    rst_pulse();
    ir[0] = 1'b1; ia[0] = 8'd2; dw[0] = 1'b1; da[0] = 8'd2; dwd[0] = 8'h5C;
    tick(); #1;
    chk("t2_grant_i", gnt[0], 2'b01);
    chk("t2_old", irdata[0], 8'hA4);
    chk("t2_dresp0", dresp[0], 1'b0);
    tick(); ir[0] = 1'b0; #1;
    chk("t2_idle", gnt[0], 2'b00);
    tick(); #1;
    chk("t2_grant_d", gnt[0], 2'b10);
    chk("t2_mwr", mwr[0], 1'b1);
    chk("t2_mwd", mwd[0], 8'h5C);
    chk("t2_dresp", dresp[0], 1'b1);
    tick(); dw[0] = 1'b0; ir[0] = 1'b1; #1;
    tick(); #1;
    chk("t2_new", irdata[0], 8'h5C);
    // I was served last, so a tie now goes to D
    tick(); ir[0] = 1'b1; dr[0] = 1'b1; #1;
    tick(); #1;
    chk("t2_tie_d", gnt[0], 2'b10);
    chk("t2_drdata", drdata[0], 8'h5C);
    tick(); ir[0] = 1'b0; dr[0] = 1'b0; #1;
    tick();

    // round-robin with both ports re-requesting after every resp
    rst_pulse();
    pi = 1'b0; pd = 1'b0;
    ir[0] = 1'b1; dr[0] = 1'b1; ia[0] = 8'd1; da[0] = 8'd4;
    for (int k = 0; k < 7; k++) begin
      tick();
      ir[0] = ~pi; dr[0] = ~pd;
      #1;
      chk($sformatf("t3_grant%0d", k), gnt[0], exp3[k]);
      pi = iresp[0]; pd = dresp[0];
    end
    tick(); ir[0] = 1'b0; dr[0] = 1'b0; #1;

    // fixed priority on instance 1, D read+write held with I waiting
    ir[1] = 1'b1; dr[1] = 1'b1; dw[1] = 1'b1; da[1] = 8'd6; dwd[1] = 8'h77; ia[1] = 8'd6;
    for (int k = 0; k < 3; k++) begin
      tick(); #1;
      chk($sformatf("t4_grant%0d", k), gnt[1], (k % 2 == 0) ? 2'b10 : 2'b00);
      chk($sformatf("t4_iresp%0d", k), iresp[1], 1'b0);
      if (k == 0) begin
        chk("t4_wr_wins_rd", mrd[1], 1'b0);
        chk("t4_wr_wins_wr", mwr[1], 1'b1);
      end
    end
    tick(); dr[1] = 1'b0; dw[1] = 1'b0; #1;
    chk("t4_idle", gnt[1], 2'b00);
    tick(); #1;
    chk("t4_grant_i", gnt[1], 2'b01);
    chk("t4_irdata", irdata[1], 8'h77);
    tick(); ir[1] = 1'b0; #1;

    // watchdog on instance 0: memory never answers
    stall[0] = 1'b1; dr[0] = 1'b1; da[0] = 8'd7;
    for (int k = 1; k < 4; k++) begin
      tick(); #1;
      chk($sformatf("t5_grant%0d", k), gnt[0], 2'b10);
      chk($sformatf("t5_noresp%0d", k), dresp[0], 1'b0);
    end
    tick(); #1;
    chk("t5_dresp", dresp[0], 1'b1);
    chk("t5_drdata", drdata[0], 8'h00);
    chk("t5_terr_early", terr[0], 1'b0);
    tick(); dr[0] = 1'b0; #1;
    chk("t5_terr", terr[0], 1'b1);
    chk("t5_idle", gnt[0], 2'b00);

    // abort: I drops before resp; last stays D so the following tie goes to I
    ir[0] = 1'b1;
    tick(); #1;
    chk("t5_terr_clr", terr[0], 1'b0);
    chk("ab_grant", gnt[0], 2'b01);
    ir[0] = 1'b0; #1;
    chk("ab_noresp", iresp[0], 1'b0);
    tick(); #1;
    chk("ab_idle", gnt[0], 2'b00);
    chk("ab_noterr", terr[0], 1'b0);
    ir[0] = 1'b1; dr[0] = 1'b1;
    tick(); #1;
    chk("ab_tie_i", gnt[0], 2'b01);
    ir[0] = 1'b0; dr[0] = 1'b0;
    tick();

    // async reset in the middle of a stalled D write
    dw[0] = 1'b1; da[0] = 8'd9; dwd[0] = 8'h33;
    tick(); #1;
    chk("t6_pre_mwr", mwr[0], 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("t6_mwr0", mwr[0], 1'b0);
    chk("t6_grant0", gnt[0], 2'b00);
    rst = 1'b0; stall[0] = 1'b0; ir[0] = 1'b1;
    tick(); #1;
    chk("t6_tie_i", gnt[0], 2'b01);
    tick(); ir[0] = 1'b0; #1;
    tick(); #1;
    chk("t6_then_d", gnt[0], 2'b10);
    tick(); dw[0] = 1'b0;
    tick();

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
